// File: rtl/cla_adder_16.sv
// 16-bit two-level carry-lookahead adder with a registered {carry_out, sum}.
// Every combinational gate is a cla_nor_gate instance, so the instance tally is the NOR-gate count.

module cla_nor_gate #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] d,
  output logic         y
);
  assign y = ~|d;
endmodule

module cla_group_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  input  logic       c_in_n,
  output logic [3:0] sum,
  output logic       gg_n,
  output logic       gp_n
);
  logic [3:0] a_n_s;
  logic [3:0] b_n_s;
  logic [3:0] g_s;
  logic [3:0] or_n_s;
  logic [3:0] p_s;
  logic [3:0] p_n_s;
  logic [2:0] g_n_s;
  logic [3:0] c_s;
  logic [3:0] c_n_s;
  logic [3:0] xa_s;
  logic [3:0] xb_s;
  logic       t10_s;
  logic       t20_s;
  logic       t21_s;
  logic       t30_s;
  logic       t31_s;
  logic       t32_s;
  logic       u0_s;
  logic       u1_s;
  logic       u2_s;
  logic       gp_s;

  assign c_s[0]   = c_in;
  assign c_n_s[0] = c_in_n;

  // p = ~(~(a|b) | a&b) reuses g, so a propagate bit costs two NORs instead of five.
  for (genvar i = 0; i < 4; i++) begin : g_bit
    cla_nor_gate #(.N(1)) u_an  (.d(a[i]),                   .y(a_n_s[i]));
    cla_nor_gate #(.N(1)) u_bn  (.d(b[i]),                   .y(b_n_s[i]));
    cla_nor_gate #(.N(2)) u_g   (.d({a_n_s[i], b_n_s[i]}),   .y(g_s[i]));
    cla_nor_gate #(.N(2)) u_orn (.d({a[i], b[i]}),           .y(or_n_s[i]));
    cla_nor_gate #(.N(2)) u_p   (.d({g_s[i], or_n_s[i]}),    .y(p_s[i]));
    cla_nor_gate #(.N(1)) u_pn  (.d(p_s[i]),                 .y(p_n_s[i]));
    cla_nor_gate #(.N(2)) u_xa  (.d({p_s[i], c_s[i]}),       .y(xa_s[i]));
    cla_nor_gate #(.N(2)) u_xb  (.d({p_n_s[i], c_n_s[i]}),   .y(xb_s[i]));
    cla_nor_gate #(.N(2)) u_s   (.d({xa_s[i], xb_s[i]}),     .y(sum[i]));
  end

  // g3 only ever appears as a leading OR term, so it needs no inverted copy.
  for (genvar i = 0; i < 3; i++) begin : g_gen_inv
    cla_nor_gate #(.N(1)) u_gn (.d(g_s[i]), .y(g_n_s[i]));
  end

  // c1 = g0 | p0 c0
  cla_nor_gate #(.N(2)) u_t10 (.d({p_n_s[0], c_n_s[0]}),               .y(t10_s));
  cla_nor_gate #(.N(2)) u_c1n (.d({g_s[0], t10_s}),                    .y(c_n_s[1]));
  cla_nor_gate #(.N(1)) u_c1  (.d(c_n_s[1]),                           .y(c_s[1]));

  // c2 = g1 | p1 g0 | p1 p0 c0
  cla_nor_gate #(.N(2)) u_t20 (.d({p_n_s[1], g_n_s[0]}),               .y(t20_s));
  cla_nor_gate #(.N(3)) u_t21 (.d({p_n_s[1], p_n_s[0], c_n_s[0]}),     .y(t21_s));
  cla_nor_gate #(.N(3)) u_c2n (.d({g_s[1], t20_s, t21_s}),             .y(c_n_s[2]));
  cla_nor_gate #(.N(1)) u_c2  (.d(c_n_s[2]),                           .y(c_s[2]));

  // c3 = g2 | p2 g1 | p2 p1 g0 | p2 p1 p0 c0
  cla_nor_gate #(.N(2)) u_t30 (.d({p_n_s[2], g_n_s[1]}),               .y(t30_s));
  cla_nor_gate #(.N(3)) u_t31 (.d({p_n_s[2], p_n_s[1], g_n_s[0]}),     .y(t31_s));
  cla_nor_gate #(.N(4)) u_t32 (.d({p_n_s[2], p_n_s[1], p_n_s[0], c_n_s[0]}), .y(t32_s));
  cla_nor_gate #(.N(4)) u_c3n (.d({g_s[2], t30_s, t31_s, t32_s}),      .y(c_n_s[3]));
  cla_nor_gate #(.N(1)) u_c3  (.d(c_n_s[3]),                           .y(c_s[3]));

  // Group generate/propagate leave the group inverted; the second level consumes them that way.
  cla_nor_gate #(.N(2)) u_u0  (.d({p_n_s[3], g_n_s[2]}),               .y(u0_s));
  cla_nor_gate #(.N(3)) u_u1  (.d({p_n_s[3], p_n_s[2], g_n_s[1]}),     .y(u1_s));
  cla_nor_gate #(.N(4)) u_u2  (.d({p_n_s[3], p_n_s[2], p_n_s[1], g_n_s[0]}), .y(u2_s));
  cla_nor_gate #(.N(4)) u_ggn (.d({g_s[3], u0_s, u1_s, u2_s}),         .y(gg_n));
  cla_nor_gate #(.N(4)) u_gp  (.d(p_n_s),                              .y(gp_s));
  cla_nor_gate #(.N(1)) u_gpn (.d(gp_s),                               .y(gp_n));
endmodule

module cla_adder_16 (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] sum,
  output logic        carry_out,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in
);
  logic [15:0] sum_s;
  logic [3:0]  gg_n_s;
  logic [3:0]  gp_n_s;
  logic [3:0]  gg_s;
  logic [4:0]  grp_c_s;
  logic [3:0]  grp_c_n_s;
  logic        c16_n_s;
  logic        v40_s;
  logic        v80_s;
  logic        v81_s;
  logic        v120_s;
  logic        v121_s;
  logic        v122_s;
  logic        w0_s;
  logic        w1_s;
  logic        w2_s;
  logic        w3_s;
  logic [15:0] sum_r;
  logic        carry_out_r;

  assign grp_c_s[0] = carry_in;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    cla_group_4 u_grp (
      .a      (a[4*k +: 4]),
      .b      (b[4*k +: 4]),
      .c_in   (grp_c_s[k]),
      .c_in_n (grp_c_n_s[k]),
      .sum    (sum_s[4*k +: 4]),
      .gg_n   (gg_n_s[k]),
      .gp_n   (gp_n_s[k])
    );
    cla_nor_gate #(.N(1)) u_gg (.d(gg_n_s[k]), .y(gg_s[k]));
  end

  cla_nor_gate #(.N(1)) u_c0n  (.d(carry_in), .y(grp_c_n_s[0]));

  // Second level: each group carry-in is a flat sum of products, never rippled from its neighbour.
  cla_nor_gate #(.N(2)) u_v40  (.d({gp_n_s[0], grp_c_n_s[0]}),                       .y(v40_s));
  cla_nor_gate #(.N(2)) u_c4n  (.d({gg_s[0], v40_s}),                                .y(grp_c_n_s[1]));
  cla_nor_gate #(.N(1)) u_c4   (.d(grp_c_n_s[1]),                                    .y(grp_c_s[1]));

  cla_nor_gate #(.N(2)) u_v80  (.d({gp_n_s[1], gg_n_s[0]}),                          .y(v80_s));
  cla_nor_gate #(.N(3)) u_v81  (.d({gp_n_s[1], gp_n_s[0], grp_c_n_s[0]}),            .y(v81_s));
  cla_nor_gate #(.N(3)) u_c8n  (.d({gg_s[1], v80_s, v81_s}),                         .y(grp_c_n_s[2]));
  cla_nor_gate #(.N(1)) u_c8   (.d(grp_c_n_s[2]),                                    .y(grp_c_s[2]));

  cla_nor_gate #(.N(2)) u_v120 (.d({gp_n_s[2], gg_n_s[1]}),                          .y(v120_s));
  cla_nor_gate #(.N(3)) u_v121 (.d({gp_n_s[2], gp_n_s[1], gg_n_s[0]}),               .y(v121_s));
  cla_nor_gate #(.N(4)) u_v122 (.d({gp_n_s[2], gp_n_s[1], gp_n_s[0], grp_c_n_s[0]}), .y(v122_s));
  cla_nor_gate #(.N(4)) u_c12n (.d({gg_s[2], v120_s, v121_s, v122_s}),               .y(grp_c_n_s[3]));
  cla_nor_gate #(.N(1)) u_c12  (.d(grp_c_n_s[3]),                                    .y(grp_c_s[3]));

  cla_nor_gate #(.N(2)) u_w0   (.d({gp_n_s[3], gg_n_s[2]}),                          .y(w0_s));
  cla_nor_gate #(.N(3)) u_w1   (.d({gp_n_s[3], gp_n_s[2], gg_n_s[1]}),               .y(w1_s));
  cla_nor_gate #(.N(4)) u_w2   (.d({gp_n_s[3], gp_n_s[2], gp_n_s[1], gg_n_s[0]}),    .y(w2_s));
  cla_nor_gate #(.N(5)) u_w3   (.d({gp_n_s, grp_c_n_s[0]}),                          .y(w3_s));
  cla_nor_gate #(.N(5)) u_c16n (.d({gg_s[3], w0_s, w1_s, w2_s, w3_s}),               .y(c16_n_s));
  cla_nor_gate #(.N(1)) u_c16  (.d(c16_n_s),                                         .y(grp_c_s[4]));

  // Output register: reset wins over capture and drops whatever was being captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r       <= 16'h0000;
      carry_out_r <= 1'b0;
    end else begin
      sum_r       <= sum_s;
      carry_out_r <= grp_c_s[4];
    end
  end

  assign sum       = sum_r;
  assign carry_out = carry_out_r;
endmodule

// File: tb/tb_cla_adder_16.sv
// Directed-vector and random bench for cla_adder_16; expected results are hand-computed or a 17-bit model.
module tb_cla_adder_16;
  logic        clk;
  logic        reset;
  logic [15:0] sum;
  logic        carry_out;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;

  int n_vec;
  int n_miss;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [16:0] want;
  } vec_t;

  vec_t vecs[17];

  cla_adder_16 dut (
    .clk       (clk),
    .reset     (reset),
    .sum       (sum),
    .carry_out (carry_out),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [16:0] want);
    n_vec++;
    if ({carry_out, sum} !== want) begin
      n_miss++;
      $display("FAIL %s: got co=%0b sum=%h, want co=%0b sum=%h",
               name, carry_out, sum, want[16], want[15:0]);
    end
  endtask

  task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    a = va;
    b = vb;
    carry_in = vc;
  endtask

  initial begin
    logic [16:0] want;
    n_vec  = 0;
    n_miss = 0;

    vecs[0]  = '{16'd10,   16'd22,   1'b0, 17'h00020};
    vecs[1]  = '{16'd10,   16'd22,   1'b1, 17'h00021};
    vecs[2]  = '{16'hFFFF, 16'h0000, 1'b1, 17'h10000};
    vecs[3]  = '{16'hFFFF, 16'h0000, 1'b0, 17'h0FFFF};
    vecs[4]  = '{16'h000F, 16'h0001, 1'b0, 17'h00010};
    vecs[5]  = '{16'h0FFF, 16'h0001, 1'b0, 17'h01000};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
    vecs[7]  = '{16'h1234, 16'h4321, 1'b0, 17'h05555};
    vecs[8]  = '{16'hAAAA, 16'h5555, 1'b1, 17'h10000};
    vecs[9]  = '{16'hAAAA, 16'h5555, 1'b0, 17'h0FFFF};
    vecs[10] = '{16'h00FF, 16'h0001, 1'b0, 17'h00100};
    vecs[11] = '{16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE};
    vecs[12] = '{16'h7FFF, 16'h0001, 1'b0, 17'h08000};
    vecs[13] = '{16'h0000, 16'h0000, 1'b1, 17'h00001};
    vecs[14] = '{16'hF0F0, 16'h0F0F, 1'b1, 17'h10000};
    vecs[15] = '{16'h1357, 16'h2468, 1'b0, 17'h037BF};
    vecs[16] = '{16'hFFF0, 16'h0010, 1'b0, 17'h10000};

    // Reset held for two clocks against all-ones operands.
    reset = 1'b1;
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk); #1;
    check("reset_clk1", 17'h00000);
    @(posedge clk); #1;
    check("reset_clk2", 17'h00000);
    reset = 1'b0;
    @(posedge clk); #1;
    check("after_reset", 17'h1FFFF);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin);
      @(posedge clk); #1;
      check($sformatf("vec[%0d]", i), vecs[i].want);
    end

    // Back-to-back pairs; the old result must hold until the edge that captures the new operands.
    drive(16'd120, 16'd82, 1'b0);
    @(posedge clk); #1;
    check("b2b_202", 17'd202);
    drive(16'd928, 16'd910, 1'b1);
    #3;
    check("b2b_hold_202", 17'd202);
    @(posedge clk); #1;
    check("b2b_1839", 17'd1839);
    drive(16'd7, 16'd1, 1'b1);
    #3;
    check("b2b_hold_1839", 17'd1839);
    @(posedge clk); #1;
    check("b2b_9", 17'd9);

    // Random stream with a single-cycle reset in the middle.
    for (int i = 0; i < 10000; i++) begin
      drive(16'($urandom()), 16'($urandom()), 1'($urandom()));
      reset = (i == 5000) ? 1'b1 : 1'b0;
      want = reset ? 17'h00000 : ({1'b0, a} + {1'b0, b} + {16'h0000, carry_in});
      @(posedge clk); #1;
      check(reset ? "rand_midreset" : $sformatf("rand[%0d]", i), want);
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
